smart_flit_credit_rx_buffer: RTL and testbench

//  Receive-side end of a credit-based SMARTPkg link. Buffers FlitFixed words from the upstream router's

---
 rtl/smart_flit_credit_rx_buffer.sv | 89 ++++++++
 tb/tb_smart_flit_credit_rx_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/smart_flit_credit_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : smart_flit_credit_rx_buffer
// Description : Receive side of a credit-based SMARTPkg link. Buffers incoming
//               flits in a DEPTH-entry FIFO and returns one registered credit
//               pulse upstream for every flit the local consumer dequeues.
// Revision    : 1.0 - initial release
// ============================================================================
module smart_flit_credit_rx_buffer #(
    parameter int DATA_WIDTH = 33,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flit_in_valid,
    input  logic [DATA_WIDTH-1:0]        flit_in_data,
    output logic                         credit_out,
    output logic                         flit_out_valid,
    output logic [DATA_WIDTH-1:0]        flit_out_data,
    input  logic                         flit_out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         overflow_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_credit;
    logic                  r_overflow;

    logic                  w_not_empty;
    logic                  w_has_room;
    logic                  w_deq;
    logic                  w_enq_ok;
    logic                  w_drop;

    // A full FIFO can still take a flit when the head leaves in the same cycle.
    assign w_not_empty = (r_count != '0);
    assign w_has_room  = (r_count < c_CNT_W'(DEPTH));
    assign w_deq       = w_not_empty & flit_out_ready;
    assign w_enq_ok    = flit_in_valid & (w_has_room | w_deq);
    assign w_drop      = flit_in_valid & ~w_enq_ok;

    assign flit_out_valid = w_not_empty;
    assign flit_out_data  = r_mem[r_rd_ptr];
    assign occupancy      = r_count;
    assign credit_out     = r_credit;
    assign overflow_err   = r_overflow;

    // Storage array; contents need no reset because valid gates the head.
    always_ff @(posedge clk) begin
        if (!reset && w_enq_ok) begin
            r_mem[r_wr_ptr] <= flit_in_data;
        end
    end

    // Pointers, occupancy, registered credit and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_credit <= w_deq;
            if (w_enq_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_enq_ok, w_deq})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smart_flit_credit_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_smart_flit_credit_rx_buffer
// Description : Directed self-checking bench for smart_flit_credit_rx_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smart_flit_credit_rx_buffer;

    localparam int DATA_WIDTH = 33;
    localparam int DEPTH      = 4;

    logic                  clk;
    logic                  reset;
    logic                  flit_in_valid;
    logic [DATA_WIDTH-1:0] flit_in_data;
    logic                  credit_out;
    logic                  flit_out_valid;
    logic [DATA_WIDTH-1:0] flit_out_data;
    logic                  flit_out_ready;
    logic [2:0]            occupancy;
    logic                  overflow_err;

    int n_checks;
    int n_pass;

    smart_flit_credit_rx_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flit_in_valid (flit_in_valid),
        .flit_in_data  (flit_in_data),
        .credit_out    (credit_out),
        .flit_out_valid(flit_out_valid),
        .flit_out_data (flit_out_data),
        .flit_out_ready(flit_out_ready),
        .occupancy     (occupancy),
        .overflow_err  (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle 1ns past it so outputs are stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_WIDTH-1:0] d);
        flit_in_valid = 1'b1;
        flit_in_data  = d;
        step();
        flit_in_valid = 1'b0;
    endtask

    logic [DATA_WIDTH-1:0] exp_q [$];
    logic [DATA_WIDTH-1:0] tv [4];
    int credits;
    int sent;
    int recv;
    int cycles;
    logic will_deq;
    logic will_enq;
    logic rdy;

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        reset          = 1'b1;
        flit_in_valid  = 1'b1;
        flit_in_data   = 33'h1_FFFF_FFFF;
        flit_out_ready = 1'b0;

        // T1: reset held two cycles with a flit offered
        step();
        step();
        flit_in_valid = 1'b0;
        reset         = 1'b0;
        check("t1_occ",    occupancy,      0);
        check("t1_valid",  flit_out_valid, 0);
        check("t1_credit", credit_out,     0);
        check("t1_ovf",    overflow_err,   0);
        step();
        check("t1_occ_after", occupancy, 0);

        // T2: single flit, one-cycle latency, credit one cycle after dequeue
        flit_out_ready = 1'b1;
        send(33'h1_2345_6789);
        check("t2_valid",   flit_out_valid, 1);
        check("t2_data",    flit_out_data,  33'h1_2345_6789);
        check("t2_occ",     occupancy,      1);
        check("t2_credit0", credit_out,     0);
        step();
        check("t2_credit1", credit_out,     1);
        check("t2_empty",   flit_out_valid, 0);
        step();
        check("t2_credit2", credit_out,     0);

        // T3: fill four with consumer stalled, then drain in order
        flit_out_ready = 1'b0;
        tv[0] = 33'h0_AAAA_0001; tv[1] = 33'h1_BBBB_0002;
        tv[2] = 33'h0_CCCC_0003; tv[3] = 33'h1_DDDD_0004;
        for (int i = 0; i < 4; i++) begin
            send(tv[i]);
            check("t3_nocredit", credit_out, 0);
        end
        check("t3_occ_full", occupancy, 4);
        flit_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_data", flit_out_data, tv[i]);
            step();
            check("t3_credit", credit_out, 1);
        end
        check("t3_occ_end", occupancy, 0);
        step();
        check("t3_credit_off", credit_out, 0);

        // T4: full FIFO accepts a flit when the head leaves in the same cycle
        flit_out_ready = 1'b0;
        tv[0] = 33'h0_0000_0E00; tv[1] = 33'h0_0000_0E01;
        tv[2] = 33'h0_0000_0E02; tv[3] = 33'h0_0000_0E03;
        for (int i = 0; i < 4; i++) send(tv[i]);
        flit_out_ready = 1'b1;
        send(33'h1_0000_0AEE);
        check("t4_occ", occupancy,    4);
        check("t4_ovf", overflow_err, 0);
        for (int i = 1; i < 4; i++) begin
            check("t4_old", flit_out_data, tv[i]);
            step();
        end
        check("t4_new", flit_out_data, 33'h1_0000_0AEE);
        step();
        check("t4_occ_end", occupancy, 0);
        flit_out_ready = 1'b0;
        step();

        // T5: overflow drops the flit, sets sticky flag, no extra credit
        tv[0] = 33'h0_F000_0000; tv[1] = 33'h0_F000_0001;
        tv[2] = 33'h0_F000_0002; tv[3] = 33'h0_F000_0003;
        for (int i = 0; i < 4; i++) send(tv[i]);
        send(33'h1_DEAD_BEEF);
        check("t5_ovf", overflow_err, 1);
        check("t5_occ", occupancy,    4);
        step();
        check("t5_ovf_sticky", overflow_err, 1);
        credits        = 0;
        flit_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_data", flit_out_data, tv[i]);
            step();
            credits += int'(credit_out);
        end
        flit_out_ready = 1'b0;
        step();
        credits += int'(credit_out);
        step();
        credits += int'(credit_out);
        check("t5_credits", credits,        4);
        check("t5_empty",   flit_out_valid, 0);
        check("t5_ovf_hold", overflow_err,  1);

        // T6a: reset clears the sticky flag, then stream 10 flits with random ready
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_ovf_reset", overflow_err, 0);
        sent = 0; recv = 0; credits = 0; cycles = 0;
        while (recv < 10 && cycles < 300) begin
            rdy            = 1'($urandom_range(0, 1));
            flit_out_ready = rdy;
            flit_in_valid  = (sent < 10) && (occupancy < 3'd4);
            flit_in_data   = {1'b1, 32'hC0DE_0000 + 32'(sent)};
            will_deq       = flit_out_valid & rdy;
            will_enq       = flit_in_valid & ((occupancy < 3'd4) | will_deq);
            if (will_deq) begin
                if (exp_q.size() == 0) begin
                    check("t6_unexpected_flit", flit_out_data, 0);
                end else begin
                    check("t6_data", flit_out_data, exp_q.pop_front());
                end
                recv++;
            end
            if (will_enq) begin
                exp_q.push_back(flit_in_data);
                sent++;
            end
            step();
            credits += int'(credit_out);
            cycles++;
        end
        flit_in_valid  = 1'b0;
        flit_out_ready = 1'b0;
        step();
        credits += int'(credit_out);
        check("t6_recv",    recv,    10);
        check("t6_credits", credits, 10);
        check("t6_occ",     occupancy, 0);

        // T6b: reset with three flits stored discards them and issues no credit
        for (int i = 0; i < 3; i++) send(33'h0_0000_0300 + 33'(i));
        check("t6_occ3", occupancy, 3);
        flit_out_ready = 1'b1;
        reset          = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_occ",    occupancy,      0);
        check("t6_rst_valid",  flit_out_valid, 0);
        check("t6_rst_credit", credit_out,     0);
        step();
        check("t6_post_credit", credit_out,     0);
        check("t6_post_valid",  flit_out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
